// File: rtl/add_arbiter.sv
// Two-requester round-robin arbiter sharing one W-bit ripple adder slice.
// Each 2W-bit add runs low half then high half, then holds the result until consumed.
module add_slice #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    logic c;

    always_comb begin
        c   = cin;
        sum = '0;
        for (int i = 0; i < W; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end
endmodule

module add_arbiter #(
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [2*W-1:0] a0,
    input  logic [2*W-1:0] b0,
    input  logic [2*W-1:0] a1,
    input  logic [2*W-1:0] b1,
    input  logic           cin0,
    input  logic           cin1,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [2*W:0]   rsp_sum,
    output logic           rsp_id
);
    typedef enum logic [1:0] {IDLE, LO, HI, RSP} state_t;

    state_t         state, state_nxt;
    logic           last;
    logic           gnt_id;
    logic [2*W-1:0] a_q, b_q;
    logic           cin_q, carry_q, id_q;
    logic [W-1:0]   lo_q;
    logic [W-1:0]   sa, sb, ssum;
    logic           scin, scout;

    // Tie goes to whoever was not granted last; a lone requester always wins.
    always_comb begin
        gnt_id    = (req_valid == 2'b11) ? ~last : req_valid[1];
        req_ready = 2'b00;
        if (rst_n && state == IDLE && req_valid != 2'b00)
            req_ready = 2'b01 << gnt_id;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid != 2'b00) state_nxt = LO;
            LO:      state_nxt = HI;
            HI:      state_nxt = RSP;
            RSP:     if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The single slice is time-shared: low half with the request carry, high half with the stored carry.
    always_comb begin
        sa   = (state == HI) ? a_q[2*W-1:W] : a_q[W-1:0];
        sb   = (state == HI) ? b_q[2*W-1:W] : b_q[W-1:0];
        scin = (state == HI) ? carry_q : cin_q;
    end

    add_slice #(.W(W)) u_slice (
        .a    (sa),
        .b    (sb),
        .cin  (scin),
        .sum  (ssum),
        .cout (scout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= 1'b1;
            a_q       <= '0;
            b_q       <= '0;
            cin_q     <= 1'b0;
            carry_q   <= 1'b0;
            id_q      <= 1'b0;
            lo_q      <= '0;
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_id    <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (req_valid != 2'b00) begin
                    a_q   <= gnt_id ? a1 : a0;
                    b_q   <= gnt_id ? b1 : b0;
                    cin_q <= gnt_id ? cin1 : cin0;
                    id_q  <= gnt_id;
                    last  <= gnt_id;
                end
                LO: begin
                    lo_q    <= ssum;
                    carry_q <= scout;
                end
                // Response registers load only here so they stay frozen through RSP.
                HI: begin
                    rsp_sum   <= {scout, ssum, lo_q};
                    rsp_id    <= id_q;
                    rsp_valid <= 1'b1;
                end
                RSP: if (rsp_ready) rsp_valid <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: doc/add_arbiter.md
ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 SHALL have parameter W, default 16, giving the width of the single shared adder slice; operands are 2*W bits wide.
REQ-002 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports req_valid[1:0], input, 2, with one request-valid bit per requester (0 and 1).
REQ-005 SHALL have ports req_ready[1:0], output, 2, where bit i high means requester i's operands are accepted this cycle.
REQ-006 SHALL have ports a0, b0, a1, b1, input, 2*W each, the operands of requesters 0 and 1.
REQ-007 SHALL have ports cin0, cin1, input, 1 each, the carry-in of requesters 0 and 1.
REQ-008 SHALL have port rsp_valid, output, 1, meaning a result is held on rsp_sum/rsp_id.
REQ-009 SHALL have port rsp_ready, input, 1, meaning the consumer accepts the result.
REQ-010 SHALL have port rsp_sum, output, 2*W+1, holding {cout, sum}.
REQ-011 SHALL have port rsp_id, output, 1, giving the index of the requester that owns rsp_sum.

Function
REQ-012 SHALL contain exactly one W-bit ripple adder slice (a, b, cin -> sum, cout) and use it for all additions.
REQ-013 SHALL implement FSM states IDLE, LO, HI, RSP.
REQ-014 IDLE: if any req_valid is set, SHALL grant one requester, assert its req_ready for exactly that cycle, capture its a, b and cin into internal registers, and go to LO; otherwise SHALL stay in IDLE.
REQ-015 Arbitration SHALL be round-robin: when both are valid, grant the requester not granted last; after reset, requester 0 wins the first tie.
REQ-016 When exactly one requester is valid, it SHALL be granted regardless of history.
REQ-017 req_ready SHALL be 0 in every state except IDLE, and at most one bit SHALL be high at a time.
REQ-018 LO: the slice SHALL add the captured low W bits with captured cin; sum is stored to result[W-1:0] and the carry is stored internally; next state is HI.
REQ-019 HI: the slice SHALL add the captured high W bits with the stored carry; sum is stored to result[2W-1:W] and cout to result[2W]; next state is RSP.
REQ-020 RSP: rsp_valid SHALL be 1, and rsp_sum and rsp_id SHALL be stable; if rsp_ready=1, go to IDLE next cycle, else hold.
REQ-021 Latency from the accept edge (req_ready&req_valid) to rsp_valid high SHALL be 3 cycles; with rsp_ready tied high, throughput SHALL be one operation per 4 cycles.
REQ-022 Arithmetic SHALL be unsigned modulo 2^(2W+1): rsp_sum = a + b + cin with no truncation of the carry.
REQ-023 Overflow wrap: all-ones + all-ones + 1 SHALL yield {1, all-ones}.
REQ-024 Operand or req_valid changes after acceptance SHALL NOT affect the in-flight result.
REQ-025 A request that drops req_valid before being granted SHALL simply be lost, with no error and no grant.
REQ-026 rsp_valid SHALL be a registered output, and rsp_sum/rsp_id SHALL change only on the HI->RSP transition.

Reset
REQ-027 On rst_n=0, regardless of clk, SHALL force state IDLE, rsp_valid=0, req_ready=0, rsp_sum=0, rsp_id=0, the stored carry 0, and round-robin pointer = "requester 0 has priority".
REQ-028 Reset asserted mid-operation (in LO, HI or RSP) SHALL discard the operation; no rsp_valid SHALL appear after release.
REQ-029 After rst_n rises, the first grant SHALL occur on the first clock edge at which req_valid is nonzero.

Verification
REQ-030 W=16, single request: req0 with a0=32'h0000FFFF, b0=32'h00000001, cin0=0 -> rsp_valid 3 cycles after accept, rsp_sum=33'h0_00010000, rsp_id=0.
REQ-031 Full overflow: a1=b1=32'hFFFFFFFF, cin1=1 -> rsp_sum=33'h1_FFFFFFFF, rsp_id=1.
REQ-032 Contention: both requesters valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1, one every 4 cycles, and each rsp_id matches its grant order.
REQ-033 Backpressure: rsp_ready=0 for 5 cycles in RSP -> rsp_valid and rsp_sum are held constant, req_ready stays 0, and no new grant occurs until the cycle after rsp_ready=1.
REQ-034 Reset during HI state -> all outputs read 0 immediately (asynchronously), no response follows, and the next tie is won by requester 0.
REQ-035 Random regression: 100 random operand/cin pairs per requester -> every rsp_sum equals a+b+cin as a 33-bit value; any mismatch stops the run and reports the index, operands, result and expected value.
